// File: rtl/conv3_3_ctrl.sv
// Control and line buffering for an external 3x3 convolution datapath.
// Loads nine filter bytes, streams a raster image, and returns one result per valid window.
module conv3_3_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        filt_valid,
  output logic        filt_ready,
  input  logic [7:0]  filt_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic [71:0] conv_filter,
  output logic [71:0] conv_window,
  input  logic [15:0] conv_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_last,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    fcnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pend, pend_last;
  logic [7:0]    lb_top [IMG_W];
  logic [7:0]    lb_mid [IMG_W];

  logic filt_acc, pix_acc, res_hs, last_pix, win_ok;

  // All streams use valid/ready: a transfer happens on a rising edge where both are high;
  // a source holds valid and data stable until that transfer.
  assign filt_acc  = filt_valid && filt_ready;
  assign pix_acc   = pix_valid && pix_ready;
  assign res_hs    = res_valid && res_ready;
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign win_ok    = (row >= RW'(2)) && (col >= CW'(2));
  assign pix_ready = (state == S_STREAM) && !pend && (!res_valid || res_ready);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    filt_ready = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        filt_ready = 1'b1;
        if (filt_valid && fcnt == 4'd8) state_nxt = S_STREAM;
      end
      S_STREAM: if (pix_acc && last_pix) state_nxt = S_FLUSH;
      S_FLUSH:  if (res_hs && res_last) state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt        <= '0;
      conv_filter <= '0;
      conv_window <= '0;
      col         <= '0;
      row         <= '0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) fcnt <= '0;
      // Shifting in from the bottom leaves byte 0 in the top byte after nine loads.
      if (filt_acc) begin
        conv_filter <= {conv_filter[63:0], filt_data};
        fcnt        <= fcnt + 4'd1;
        if (fcnt == 4'd8) begin
          col <= '0;
          row <= '0;
        end
      end
      if (pix_acc) begin
        conv_window <= {conv_window[63:48], lb_top[col],
                        conv_window[39:24], lb_mid[col],
                        conv_window[15:0],  pix_data};
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (win_ok) begin
          pend      <= 1'b1;
          pend_last <= last_pix;
        end
      end
      // pix_ready guarantees res_valid is low or being consumed whenever pend is set.
      if (pend) begin
        pend      <= 1'b0;
        res_valid <= 1'b1;
        res_data  <= conv_res;
        res_last  <= pend_last;
      end else if (res_hs) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end
    end
  end

  // Line buffers are gated by the row counter, so they need no reset.
  always_ff @(posedge clk) begin
    if (pix_acc) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pix_data;
    end
  end

endmodule

// File: tb/tb_conv3_3_ctrl.sv
// Bench for conv3_3_ctrl on a 4x4 image with a behavioural 3x3 multiply-accumulate datapath.
module tb_conv3_3_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic        filt_valid, filt_ready;
  logic [7:0]  filt_data;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_data;
  logic [71:0] conv_filter, conv_window;
  logic [15:0] conv_res;
  logic        res_valid, res_ready, res_last;
  logic [15:0] res_data;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int res_cnt = 0;
  int done_cnt = 0;
  bit rr_stop;
  logic [16:0] exp_q[$];
  logic [7:0]  filt_arr[9];
  logic [7:0]  img[N];

  conv3_3_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .conv_filter(conv_filter), .conv_window(conv_window), .conv_res(conv_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // external datapath: unsigned MAC wrapping at 16 bits
  always_comb begin
    conv_res = '0;
    for (int k = 0; k < 9; k++)
      conv_res = conv_res + (16'(conv_filter[8*k +: 8]) * 16'(conv_window[8*k +: 8]));
  end

  // scoreboard: pop on each result handshake
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && res_valid && res_ready) begin
      checks++;
      res_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected: got data=%0d last=%0b, none expected", res_data, res_last);
      end else begin
        e = exp_q.pop_front();
        if ({res_last, res_data} !== e) begin
          errors++;
          $display("FAIL res_data: got data=%0d last=%0b, want data=%0d last=%0b",
                   res_data, res_last, e[15:0], e[16]);
        end
      end
    end
    if (rst_n && done) done_cnt++;
  end

  // driver tasks
  task automatic do_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_filt(input logic [7:0] d);
    int n = 0;
    filt_valid = 1'b1;
    filt_data  = d;
    @(negedge clk);
    while (!filt_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!filt_ready) begin
      errors++;
      $display("FAIL filt_timeout: filt_ready=%0b, want 1", filt_ready);
    end
    @(posedge clk); #1;
    filt_valid = 1'b0;
  endtask

  task automatic load_filter();
    do_start();
    for (int k = 0; k < 9; k++) drive_filt(filt_arr[k]);
  endtask

  task automatic push_expect(input int i);
    int r, c, s;
    r = i / W;
    c = i % W;
    if (r >= 2 && c >= 2) begin
      s = 0;
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          s += int'(filt_arr[rr*3 + cc]) * int'(img[(r-2+rr)*W + (c-2+cc)]);
      exp_q.push_back({(i == N-1) ? 1'b1 : 1'b0, s[15:0]});
    end
  endtask

  task automatic drive_pix(input logic [7:0] d);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    @(negedge clk);
    while (!pix_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!pix_ready) begin
      errors++;
      $display("FAIL pix_timeout: pix_ready=%0b, want 1", pix_ready);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_pixels(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      push_expect(i);
      drive_pix(img[i]);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done=%0b, want 1", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input int r0, input int d0);
    logic [71:0] ef;
    ef = '0;
    for (int k = 0; k < 9; k++) ef = {ef[63:0], filt_arr[k]};
    @(negedge clk);
    checks++;
    if (res_cnt - r0 !== 4) begin
      errors++; $display("FAIL frame_results: got %0d, want 4", res_cnt - r0);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL frame_done_pulses: got %0d, want 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL frame_leftover: %0d results still expected, want 0", exp_q.size());
    end
    checks++;
    if (dbg_state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL frame_idle: state=%0d busy=%0b, want 0/0", dbg_state, busy);
    end
    checks++;
    if (conv_filter !== ef) begin
      errors++; $display("FAIL filter_persist: got %h, want %h", conv_filter, ef);
    end
    exp_q.delete();
  endtask

  task automatic set_ones();
    for (int k = 0; k < 9; k++) filt_arr[k] = 8'h01;
    for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; filt_valid = 1'b0; filt_data = '0;
    pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, filt_ready, pix_ready, res_valid, res_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%0b done=%0b fr=%0b pr=%0b rv=%0b rl=%0b, want all 0",
               busy, done, filt_ready, pix_ready, res_valid, res_last);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d, want 0", dbg_state);
    end
    checks++;
    if (res_data !== 16'd0 || conv_filter !== 72'd0 || conv_window !== 72'd0) begin
      errors++;
      $display("FAIL reset_data: res=%h filt=%h win=%h, want zeros", res_data, conv_filter, conv_window);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int r0 = res_cnt;
    int d0 = done_cnt;
    res_ready = 1'b1;
    set_ones();
    load_filter();
    checks++;
    if (dbg_state !== 3'd2 || filt_ready !== 1'b0) begin
      errors++; $display("FAIL basic_stream_entry: state=%0d fr=%0b, want 2/0", dbg_state, filt_ready);
    end
    send_pixels(0, 10);
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || pix_ready !== 1'b0) begin
      errors++; $display("FAIL basic_latency1: rv=%0b pr=%0b, want 0/0", res_valid, pix_ready);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'd54) begin
      errors++; $display("FAIL basic_latency2: rv=%0b data=%0d, want 1/54", res_valid, res_data);
    end
    @(posedge clk); #1;
    send_pixels(11, 15);
    wait_done();
    check_frame(r0, d0);
  endtask

  task automatic test_wrap();
    int r0 = res_cnt;
    int d0 = done_cnt;
    res_ready = 1'b1;
    for (int k = 0; k < 9; k++) filt_arr[k] = 8'hFF;
    for (int i = 0; i < N; i++) img[i] = 8'hFF;
    load_filter();
    send_pixels(0, 10);
    repeat (2) @(negedge clk);
    checks++;
    if (res_data !== 16'hEE09) begin
      errors++; $display("FAIL wrap_value: got %h, want ee09", res_data);
    end
    @(posedge clk); #1;
    send_pixels(11, N-1);
    wait_done();
    check_frame(r0, d0);
  endtask

  task automatic stall_ctl();
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (!res_valid) begin
      errors++; $display("FAIL stall_timeout: res_valid=%0b, want 1", res_valid);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (res_data !== 16'd54 || res_valid !== 1'b1 || pix_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cyc=%0d data=%0d rv=%0b pr=%0b, want 54/1/0",
                 i, res_data, res_valid, pix_ready);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
  endtask

  task automatic test_stall();
    int r0 = res_cnt;
    int d0 = done_cnt;
    set_ones();
    res_ready = 1'b1;
    load_filter();
    res_ready = 1'b0;
    fork
      send_pixels(0, N-1);
      stall_ctl();
    join
    wait_done();
    check_frame(r0, d0);
  endtask

  task automatic test_ignore();
    int r0 = res_cnt;
    int d0 = done_cnt;
    set_ones();
    res_ready = 1'b1;
    load_filter();
    send_pixels(0, 4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL ignore_start: state=%0d busy=%0b, want 2/1", dbg_state, busy);
    end
    @(posedge clk); #1;
    filt_valid = 1'b1;
    filt_data  = 8'hAA;
    @(negedge clk);
    checks++;
    if (filt_ready !== 1'b0) begin
      errors++; $display("FAIL ignore_filt_ready: got %0b, want 0", filt_ready);
    end
    @(posedge clk); #1;
    filt_valid = 1'b0;
    checks++;
    if (conv_filter !== {9{8'h01}}) begin
      errors++; $display("FAIL ignore_filt_data: got %h, want all 01", conv_filter);
    end
    send_pixels(5, N-1);
    wait_done();
    check_frame(r0, d0);
  endtask

  task automatic test_reset_mid();
    int r0, d0;
    set_ones();
    res_ready = 1'b1;
    load_filter();
    send_pixels(0, 9);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd0 || res_valid !== 1'b0 || pix_ready !== 1'b0 || conv_filter !== 72'd0) begin
      errors++;
      $display("FAIL midreset_state: state=%0d rv=%0b pr=%0b filt=%h, want 0/0/0/0",
               dbg_state, res_valid, pix_ready, conv_filter);
    end
    exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    r0 = res_cnt;
    d0 = done_cnt;
    load_filter();
    send_pixels(0, N-1);
    wait_done();
    check_frame(r0, d0);
  endtask

  task automatic test_random();
    int r0 = res_cnt;
    int d0 = done_cnt;
    for (int k = 0; k < 9; k++) filt_arr[k] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    res_ready = 1'b1;
    load_filter();
    rr_stop = 1'b0;
    fork
      while (!rr_stop) begin
        @(posedge clk); #1;
        res_ready = 1'($urandom_range(0, 1));
      end
    join_none
    send_pixels(0, N-1);
    wait_done();
    rr_stop = 1'b1;
    @(posedge clk); #2;
    res_ready = 1'b1;
    check_frame(r0, d0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_ignore();
    test_reset_mid();
    for (int t = 0; t < 4; t++) test_random();
    test_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
